ntt_core_cut_sequencer: RTL and testbench
=========================================

NTT_CORE_CUT_SEQUENCER -- requirements
Module: ntt_core_cut_sequencer

Interface
REQ-001 The block SHALL have parameter NTT_RDX_CUT_NB, default 3, the number of radix columns.
REQ-002 The block SHALL have parameter NTT_RDX_CUT_S, default {32'd3,32'd4,32'd4}, packed [NTT_RDX_CUT_NB-1:0][31:0], log2 radix per column; [0] is the first negacyclic column.
REQ-003 The block SHALL derive localparam LOG_N = sum of NTT_RDX_CUT_S (default 11), COL_W = max(1, clog2(NTT_RDX_CUT_NB)) (default 2), and GRP_W = LOG_N - min(NTT_RDX_CUT_S) (default 8).
REQ-004 clk  in  1  single clock; all logic rising-edge.
REQ-005 s_rst_n  in  1  reset, asynchronous, active-low.
REQ-006 cmd_vld  in  1  NTT command valid.
REQ-007 cmd_rdy  out  1  command accepted when cmd_vld & cmd_rdy.
REQ-008 cmd_bwd  in  1  0 = forward (columns 0..NB-1); 1 = backward (columns NB-1..0).
REQ-009 ctrl_vld  out  1  control token valid.
REQ-010 ctrl_rdy  in  1  downstream accepts token.
REQ-011 ctrl_col  out  COL_W  current column index.
REQ-012 ctrl_rdx_log  out  3  NTT_RDX_CUT_S[ctrl_col], truncated to 3 bits.
REQ-013 ctrl_grp  out  GRP_W  butterfly group index within column, zero-extended.
REQ-014 ctrl_soc / ctrl_eoc  out  1 each  first / last group of column.
REQ-015 ctrl_eon  out  1  last token of the whole NTT.
REQ-016 busy  out  1  command in progress.

Function
REQ-017 The FSM SHALL have states IDLE and RUN; cmd_rdy = 1 only in IDLE.
REQ-018 On cmd_vld & cmd_rdy, the block SHALL latch cmd_bwd, load column = 0 (fwd) or NB-1 (bwd), load group = 0, and enter RUN on the next edge.
REQ-019 In RUN, ctrl_vld SHALL be 1 every cycle; in IDLE, ctrl_vld SHALL be 0.
REQ-020 Column c SHALL emit G_c = 2^(LOG_N - S[c]) tokens with ctrl_grp 0..G_c-1 in ascending order (default: 128, 128, 256).
REQ-021 The token, column and group counters SHALL advance only on ctrl_vld & ctrl_rdy.
REQ-022 While ctrl_vld & !ctrl_rdy, every ctrl_* output SHALL stay stable.
REQ-023 ctrl_soc SHALL be 1 iff group = 0; ctrl_eoc SHALL be 1 iff group = G_c-1.
REQ-024 ctrl_eon SHALL be 1 iff ctrl_eoc is 1 and the column is the last in traversal order (NB-1 fwd, 0 bwd).
REQ-025 A transfer with ctrl_eoc and not ctrl_eon SHALL reset group to 0 and step the column by +1 (fwd) or -1 (bwd).
REQ-026 A transfer with ctrl_eon SHALL return the FSM to IDLE; cmd_rdy SHALL be 1 in the following cycle.
REQ-027 First-token latency SHALL be exactly 1 cycle after command acceptance.
REQ-028 No command SHALL be accepted on the same cycle as the ctrl_eon transfer (no back-to-back overlap).
REQ-029 The total token count per command SHALL be sum of G_c (default 512), with no bubbles when ctrl_rdy is held at 1.
REQ-030 busy SHALL equal (state == RUN).
REQ-031 The block SHALL not accept a parameter set with NTT_RDX_CUT_S[c] outside 1..6; an elaboration-time check SHALL fail on any such value.

Reset
REQ-032 While s_rst_n = 0, asynchronously: state = IDLE, cmd_rdy = 1, ctrl_vld = 0, busy = 0, ctrl_col = 0, ctrl_grp = 0, and ctrl_soc, ctrl_eoc, ctrl_eon, ctrl_rdx_log = 0.
REQ-033 An assertion of reset mid-RUN SHALL abort the command with no further tokens; after deassertion the block SHALL be in IDLE and accept a new command.

Verification
REQ-034 Forward command, ctrl_rdy = 1 -> 512 consecutive tokens: col 0 grp 0..127, col 1 grp 0..127, col 2 grp 0..255; soc at tokens 0, 128, 256; eoc at 127, 255, 511; eon only at 511; cmd_rdy = 1 at cycle 513 after acceptance.
REQ-035 Backward command -> col 2 grp 0..255 (rdx_log 3), then col 1 and col 0 at 128 each (rdx_log 4); eon on col 0 grp 127.
REQ-036 Random ctrl_rdy back-pressure (50%) -> identical token sequence to REQ-034, outputs stable during every stall, and never more than one transfer per cycle.
REQ-037 cmd_vld held at 1 continuously -> exactly one command accepted per 513-cycle period; cmd_rdy = 0 throughout RUN.
REQ-038 Reset asserted at token 200 -> ctrl_vld = 0 immediately (asynchronous); after release, a new forward command restarts at col 0 grp 0.
REQ-039 Parameter override NB = 2, S = {5,6} -> col 0 emits 32 groups and col 1 emits 64 groups; GRP_W = 6.

Source files
------------

// File: rtl/ntt_core_cut_sequencer.sv
// Radix-column / butterfly-group token sequencer for a multi-column NTT core.
// One accepted command yields one control token per butterfly group of every column.

package ntt_core_cut_sequencer_pkg;

    localparam int MAX_NB = 32;

    typedef logic [MAX_NB-1:0][31:0] rdx_vec_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    function automatic int rdx_sum(input rdx_vec_t s, input int nb);
        int acc;
        acc = 0;
        for (int c = 0; c < nb; c++) begin
            acc += int'(s[c]);
        end
        return acc;
    endfunction

    function automatic int rdx_min(input rdx_vec_t s, input int nb);
        int m;
        m = int'(s[0]);
        for (int c = 1; c < nb; c++) begin
            if (int'(s[c]) < m) begin
                m = int'(s[c]);
            end
        end
        return m;
    endfunction

endpackage

module ntt_core_cut_sequencer
    import ntt_core_cut_sequencer_pkg::*;
#(
    parameter int                                NTT_RDX_CUT_NB = 3,
    parameter logic [NTT_RDX_CUT_NB-1:0][31:0]   NTT_RDX_CUT_S  = {32'd3, 32'd4, 32'd4},
    localparam int LOG_N = rdx_sum((MAX_NB*32)'(NTT_RDX_CUT_S), NTT_RDX_CUT_NB),
    localparam int COL_W = (NTT_RDX_CUT_NB > 1) ? $clog2(NTT_RDX_CUT_NB) : 1,
    localparam int GRP_W = LOG_N - rdx_min((MAX_NB*32)'(NTT_RDX_CUT_S), NTT_RDX_CUT_NB)
) (
    input  logic             clk,
    input  logic             s_rst_n,
    input  logic             cmd_vld,
    output logic             cmd_rdy,
    input  logic             cmd_bwd,
    output logic             ctrl_vld,
    input  logic             ctrl_rdy,
    output logic [COL_W-1:0] ctrl_col,
    output logic [2:0]       ctrl_rdx_log,
    output logic [GRP_W-1:0] ctrl_grp,
    output logic             ctrl_soc,
    output logic             ctrl_eoc,
    output logic             ctrl_eon,
    output logic             busy
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(NTT_RDX_CUT_NB - 1);

    // Only radix 2^1..2^6 butterflies exist, and at least two columns are needed for a group index.
    if (NTT_RDX_CUT_NB < 2 || NTT_RDX_CUT_NB > MAX_NB) begin : g_bad_nb
        $error("ntt_core_cut_sequencer: NTT_RDX_CUT_NB out of range");
    end
    for (genvar c = 0; c < NTT_RDX_CUT_NB; c++) begin : g_chk_s
        if (NTT_RDX_CUT_S[c] < 32'd1 || NTT_RDX_CUT_S[c] > 32'd6) begin : g_bad_s
            $error("ntt_core_cut_sequencer: NTT_RDX_CUT_S entry outside 1..6");
        end
    end

    state_e           state_q, state_d;
    logic             bwd_q, bwd_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [GRP_W-1:0] grp_q, grp_d;

    logic [GRP_W-1:0] grp_last;
    logic [2:0]       rdx_log;
    logic             run, last_col, soc, eoc, eon;

    // Per-column constants selected by the current column: last group index and log2 radix.
    always_comb begin
        grp_last = '0;
        rdx_log  = '0;
        for (int c = 0; c < NTT_RDX_CUT_NB; c++) begin
            if (col_q == COL_W'(c)) begin
                grp_last = GRP_W'((32'd1 << (LOG_N - int'(NTT_RDX_CUT_S[c]))) - 32'd1);
                rdx_log  = NTT_RDX_CUT_S[c][2:0];
            end
        end
    end

    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        bwd_d    = bwd_q;
        col_d    = col_q;
        grp_d    = grp_q;
        run      = (state_q == ST_RUN);
        last_col = bwd_q ? (col_q == '0) : (col_q == COL_LAST);
        soc      = (grp_q == '0);
        eoc      = (grp_q == grp_last);
        eon      = eoc & last_col;

        case (state_q)
            ST_IDLE: begin
                if (cmd_vld) begin
                    state_d = ST_RUN;
                    bwd_d   = cmd_bwd;
                    col_d   = cmd_bwd ? COL_LAST : '0;
                    grp_d   = '0;
                end
            end
            ST_RUN: begin
                if (ctrl_rdy) begin
                    if (eon) begin
                        state_d = ST_IDLE;
                        col_d   = '0;
                        grp_d   = '0;
                    end else if (eoc) begin
                        grp_d = '0;
                        col_d = bwd_q ? (col_q - COL_W'(1)) : (col_q + COL_W'(1));
                    end else begin
                        grp_d = grp_q + GRP_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so all flops see pre-edge values.
    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_q <= ST_IDLE;
            bwd_q   <= 1'b0;
            col_q   <= '0;
            grp_q   <= '0;
        end else begin
            state_q <= state_d;
            bwd_q   <= bwd_d;
            col_q   <= col_d;
            grp_q   <= grp_d;
        end
    end

    // Token fields come straight from registers, so they hold steady while downstream stalls.
    assign cmd_rdy      = (state_q == ST_IDLE);
    assign ctrl_vld     = run;
    assign busy         = run;
    assign ctrl_col     = run ? col_q : '0;
    assign ctrl_grp     = run ? grp_q : '0;
    assign ctrl_rdx_log = run ? rdx_log : '0;
    assign ctrl_soc     = run & soc;
    assign ctrl_eoc     = run & eoc;
    assign ctrl_eon     = run & eon;

endmodule

// File: tb/tb_ntt_core_cut_sequencer.sv
// Directed bench for ntt_core_cut_sequencer: default 3-column config plus a 2-column override.
// Boundary tokens come from a hand-filled table; full sequences from a small traversal model.
module tb_ntt_core_cut_sequencer;

    localparam int NB_A = 3;
    localparam logic [NB_A-1:0][31:0] S_A = {32'd3, 32'd4, 32'd4};
    localparam int NB_B = 2;
    localparam logic [NB_B-1:0][31:0] S_B = {32'd5, 32'd6};
    localparam int LOG_N = 11;

    typedef struct {
        int col;
        int grp;
        int rdx;
        bit soc;
        bit eoc;
        bit eon;
    } token_t;

    typedef struct {
        int bwd;
        int idx;
        int col;
        int grp;
        int rdx;
        int soc;
        int eoc;
        int eon;
    } vec_t;

    logic clk = 1'b0;
    logic s_rst_n;

    logic       a_cmd_vld, a_cmd_bwd, a_ctrl_rdy;
    logic       a_cmd_rdy, a_ctrl_vld, a_soc, a_eoc, a_eon, a_busy;
    logic [1:0] a_col;
    logic [2:0] a_rdx;
    logic [7:0] a_grp;

    logic       b_cmd_vld, b_cmd_bwd, b_ctrl_rdy;
    logic       b_cmd_rdy, b_ctrl_vld, b_soc, b_eoc, b_eon, b_busy;
    logic [0:0] b_col;
    logic [2:0] b_rdx;
    logic [5:0] b_grp;

    int checks = 0;
    int errors = 0;
    bit sel = 1'b0;
    token_t got[$];
    token_t exp_q[$];
    vec_t   vecs[12];

    always #5 clk = ~clk;

    ntt_core_cut_sequencer u_dut_a (
        .clk          (clk),
        .s_rst_n      (s_rst_n),
        .cmd_vld      (a_cmd_vld),
        .cmd_rdy      (a_cmd_rdy),
        .cmd_bwd      (a_cmd_bwd),
        .ctrl_vld     (a_ctrl_vld),
        .ctrl_rdy     (a_ctrl_rdy),
        .ctrl_col     (a_col),
        .ctrl_rdx_log (a_rdx),
        .ctrl_grp     (a_grp),
        .ctrl_soc     (a_soc),
        .ctrl_eoc     (a_eoc),
        .ctrl_eon     (a_eon),
        .busy         (a_busy)
    );

    ntt_core_cut_sequencer #(
        .NTT_RDX_CUT_NB (NB_B),
        .NTT_RDX_CUT_S  (S_B)
    ) u_dut_b (
        .clk          (clk),
        .s_rst_n      (s_rst_n),
        .cmd_vld      (b_cmd_vld),
        .cmd_rdy      (b_cmd_rdy),
        .cmd_bwd      (b_cmd_bwd),
        .ctrl_vld     (b_ctrl_vld),
        .ctrl_rdy     (b_ctrl_rdy),
        .ctrl_col     (b_col),
        .ctrl_rdx_log (b_rdx),
        .ctrl_grp     (b_grp),
        .ctrl_soc     (b_soc),
        .ctrl_eoc     (b_eoc),
        .ctrl_eon     (b_eon),
        .busy         (b_busy)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int pack(input token_t t);
        return (t.col << 20) | (t.rdx << 16) | (t.grp << 3)
             | (int'(t.soc) << 2) | (int'(t.eoc) << 1) | int'(t.eon);
    endfunction

    function automatic token_t sample();
        token_t t;
        if (sel) begin
            t.col = int'(b_col); t.grp = int'(b_grp); t.rdx = int'(b_rdx);
            t.soc = b_soc; t.eoc = b_eoc; t.eon = b_eon;
        end else begin
            t.col = int'(a_col); t.grp = int'(a_grp); t.rdx = int'(a_rdx);
            t.soc = a_soc; t.eoc = a_eoc; t.eon = a_eon;
        end
        return t;
    endfunction

    function automatic bit obs_vld();
        return sel ? b_ctrl_vld : a_ctrl_vld;
    endfunction

    function automatic bit obs_cmd_rdy();
        return sel ? b_cmd_rdy : a_cmd_rdy;
    endfunction

    function automatic bit obs_busy();
        return sel ? b_busy : a_busy;
    endfunction

    task automatic drive_cmd(input bit vld, input bit bwd);
        if (sel) begin b_cmd_vld = vld; b_cmd_bwd = bwd; end
        else     begin a_cmd_vld = vld; a_cmd_bwd = bwd; end
    endtask

    task automatic drive_rdy(input bit r);
        if (sel) b_ctrl_rdy = r;
        else     a_ctrl_rdy = r;
    endtask

    function automatic int s_of(input int c);
        return sel ? int'(S_B[c]) : int'(S_A[c]);
    endfunction

    // Reference traversal: columns in command order, groups ascending within each column.
    function automatic void build_exp(input bit bwd);
        int nb;
        nb = sel ? NB_B : NB_A;
        exp_q.delete();
        for (int k = 0; k < nb; k++) begin
            int c;
            int s;
            int g;
            token_t t;
            c = bwd ? (nb - 1 - k) : k;
            s = s_of(c);
            g = 1 << (LOG_N - s);
            for (int j = 0; j < g; j++) begin
                t.col = c; t.grp = j; t.rdx = s;
                t.soc = (j == 0);
                t.eoc = (j == g - 1);
                t.eon = (j == g - 1) && (k == nb - 1);
                exp_q.push_back(t);
            end
        end
    endfunction

    task automatic run_cmd(input bit bwd, input bit rnd);
        int     guard;
        int     cycles;
        bit     done;
        bit     stalled;
        bit     r;
        token_t cur;
        token_t held;
        got.delete();
        guard = 0;
        while (!obs_cmd_rdy() && guard < 2000) begin
            step();
            guard++;
        end
        drive_cmd(1'b1, bwd);
        step();
        drive_cmd(1'b0, 1'b0);
        check("first_token_latency", int'(obs_vld()), 1);
        check("busy_in_run", int'(obs_busy()), 1);
        check("cmd_rdy_in_run", int'(obs_cmd_rdy()), 0);
        done = 0; stalled = 0; cycles = 0;
        while (!done && cycles < 4000) begin
            cur = sample();
            if (stalled) check("stall_stable", pack(cur), pack(held));
            r = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            drive_rdy(r);
            stalled = 0;
            if (obs_vld() && r) begin
                got.push_back(cur);
                if (cur.eon) done = 1;
            end else if (obs_vld()) begin
                stalled = 1;
                held = cur;
            end
            step();
            cycles++;
        end
        check("eon_reached", int'(done), 1);
        if (!rnd) check("no_bubbles", cycles, got.size());
        check("cmd_rdy_after_eon", int'(obs_cmd_rdy()), 1);
        check("vld_after_eon", int'(obs_vld()), 0);
        drive_rdy(1'b0);
    endtask

    task automatic compare_seq(input string name);
        int n;
        check({name, "_len"}, got.size(), exp_q.size());
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_tok%0d", name, i), pack(got[i]), pack(exp_q[i]));
        end
    endtask

    task automatic apply_table(input int bwd);
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].bwd == bwd) begin
                check($sformatf("vec%0d_present", i), int'(got.size() > vecs[i].idx), 1);
                if (got.size() > vecs[i].idx) begin
                    check($sformatf("vec%0d_col", i), got[vecs[i].idx].col, vecs[i].col);
                    check($sformatf("vec%0d_grp", i), got[vecs[i].idx].grp, vecs[i].grp);
                    check($sformatf("vec%0d_rdx", i), got[vecs[i].idx].rdx, vecs[i].rdx);
                    check($sformatf("vec%0d_flags", i),
                          int'({got[vecs[i].idx].soc, got[vecs[i].idx].eoc, got[vecs[i].idx].eon}),
                          (vecs[i].soc << 2) | (vecs[i].eoc << 1) | vecs[i].eon);
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n_acc;
        int prev;
        int bad_gap;
        int overlap;
        int guard;

        //            bwd  idx  col  grp  rdx soc eoc eon
        vecs[0]  = '{0,   0,   0,   0,   4,  1,  0,  0};
        vecs[1]  = '{0,   127, 0,   127, 4,  0,  1,  0};
        vecs[2]  = '{0,   128, 1,   0,   4,  1,  0,  0};
        vecs[3]  = '{0,   255, 1,   127, 4,  0,  1,  0};
        vecs[4]  = '{0,   256, 2,   0,   3,  1,  0,  0};
        vecs[5]  = '{0,   511, 2,   255, 3,  0,  1,  1};
        vecs[6]  = '{1,   0,   2,   0,   3,  1,  0,  0};
        vecs[7]  = '{1,   255, 2,   255, 3,  0,  1,  0};
        vecs[8]  = '{1,   256, 1,   0,   4,  1,  0,  0};
        vecs[9]  = '{1,   383, 1,   127, 4,  0,  1,  0};
        vecs[10] = '{1,   384, 0,   0,   4,  1,  0,  0};
        vecs[11] = '{1,   511, 0,   127, 4,  0,  1,  1};

        s_rst_n = 1'b0;
        a_cmd_vld = 0; a_cmd_bwd = 0; a_ctrl_rdy = 0;
        b_cmd_vld = 0; b_cmd_bwd = 0; b_ctrl_rdy = 0;
        #1;
        check("rst_cmd_rdy", int'(a_cmd_rdy), 1);
        check("rst_ctrl_vld", int'(a_ctrl_vld), 0);
        check("rst_busy", int'(a_busy), 0);
        check("rst_col", int'(a_col), 0);
        check("rst_grp", int'(a_grp), 0);
        check("rst_flags_rdx", int'({a_soc, a_eoc, a_eon, a_rdx}), 0);
        repeat (3) @(posedge clk);
        #1 s_rst_n = 1'b1;
        step();

        sel = 0;
        run_cmd(1'b0, 1'b0);
        apply_table(0);
        build_exp(1'b0);
        compare_seq("fwd");

        run_cmd(1'b1, 1'b0);
        apply_table(1);
        build_exp(1'b1);
        compare_seq("bwd");

        run_cmd(1'b0, 1'b1);
        build_exp(1'b0);
        compare_seq("fwd_backpressure");

        // cmd_vld held high: one acceptance per 513-cycle period, never during RUN.
        a_ctrl_rdy = 1; a_cmd_bwd = 0; a_cmd_vld = 1;
        n_acc = 0; prev = -1; bad_gap = 0; overlap = 0;
        for (int n = 0; n < 1030; n++) begin
            if (a_cmd_rdy) begin
                if (prev >= 0 && n - prev != 513) bad_gap++;
                prev = n;
                n_acc++;
            end
            if (a_ctrl_vld && a_cmd_rdy) overlap++;
            step();
        end
        a_cmd_vld = 0;
        check("held_vld_accepts", n_acc, 3);
        check("held_vld_gaps", bad_gap, 0);
        check("held_vld_overlap", overlap, 0);
        guard = 0;
        while (!a_cmd_rdy && guard < 600) begin
            step();
            guard++;
        end
        check("held_vld_drain", int'(a_cmd_rdy), 1);

        // Abort mid-run with an asynchronous reset at token 200.
        a_ctrl_rdy = 1;
        a_cmd_vld = 1;
        step();
        a_cmd_vld = 0;
        for (int n = 0; n < 200; n++) step();
        check("pre_reset_col", int'(a_col), 1);
        check("pre_reset_grp", int'(a_grp), 72);
        #2 s_rst_n = 1'b0;
        #1;
        check("async_rst_vld", int'(a_ctrl_vld), 0);
        check("async_rst_busy", int'(a_busy), 0);
        check("async_rst_cmd_rdy", int'(a_cmd_rdy), 1);
        check("async_rst_col_grp", int'({a_col, a_grp}), 0);
        step();
        check("rst_held_vld", int'(a_ctrl_vld), 0);
        s_rst_n = 1'b1;
        a_ctrl_rdy = 0;
        step();
        check("post_rst_idle", int'(a_cmd_rdy), 1);
        run_cmd(1'b0, 1'b0);
        build_exp(1'b0);
        compare_seq("after_reset");

        // Two-column override: 32 groups of radix 2^6, then 64 groups of radix 2^5.
        sel = 1;
        run_cmd(1'b0, 1'b0);
        check("b_len", got.size(), 96);
        if (got.size() == 96) begin
            check("b_col0_last_grp", got[31].grp, 31);
            check("b_col0_eoc", int'(got[31].eoc), 1);
            check("b_col1_first", pack(got[32]), (1 << 20) | (5 << 16) | (1 << 2));
            check("b_col1_last_grp", got[95].grp, 63);
            check("b_eon", int'(got[95].eon), 1);
            check("b_rdx_col0", got[0].rdx, 6);
        end
        build_exp(1'b0);
        compare_seq("b_fwd");
        run_cmd(1'b1, 1'b1);
        build_exp(1'b1);
        compare_seq("b_bwd_backpressure");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
